oled_spi_stream: RTL
====================

Name: oled_spi_stream

Overview:
- AHB-Lite slave that drives the OLED serial interface (nCS, DnC, SDIN, SCLK) from a parametrised TX FIFO of command/data bytes.
- Successor to the fixed-rate OLED serialiser. Adds a programmable SCLK divider, FIFO buffering with status and sticky overflow, and a hardware pixel-fill engine that streams one 16-bit colour N times.
- Sits on the AHB bus beside the existing OLED manager. Software builds frames with it without polling per byte.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- DIV_WIDTH, 8, width of the SCLK divider register.
- DEFAULT_DIV, 0, reset value of the divider.
- FILL_WIDTH, 16, width of the pixel-fill repeat counter.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite select, ready, write.
- HADDR, HWDATA  in  32 each  AHB address, write data.
- HSIZE  in  3  word accesses only; ignored.
- HTRANS  in  2  AHB transfer type.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  always 1.
- nCS, DnC, SDIN, SCLK  out  1 each  OLED serial interface.
- IRQ  out  1  level interrupt: idle and drained.

Behaviour:
- Clock and reset: single clock HCLK. Reset is asynchronous, active-low on HRESETn.
- Reset values: nCS=1, SCLK=0, SDIN=0, DnC=0, IRQ=0, HRDATA=0, HREADYOUT=1. FIFO is empty, the divider register holds DEFAULT_DIV, and all other registers are 0.
- AHB address phase is registered when HSEL & HREADY & HTRANS!=0. The word offset is HADDR[4:2].
- AHB writes take effect in the data phase using HWDATA. Reads return combinationally in the data phase. No wait states.
- Register map (word offsets):
  - 0 TXDATA (W): HWDATA[8]=DnC, HWDATA[7:0]=byte; pushes one entry. If the FIFO is full the entry is dropped and OVF is set.
  - 1 COLOUR (RW): 16-bit fill colour.
  - 2 FILLCNT (W): starts a fill of N=HWDATA[FILL_WIDTH-1:0] pixels.
    - Accepted only if the FIFO is empty, no fill is active and the serialiser is in IDLE.
    - Otherwise the write is ignored and ERR is set.
    - N=0 is a no-op.
  - 3 STATUS (R): bit0 busy (state!=IDLE or fill active), bit1 empty, bit2 full, bit3 OVF, bit4 ERR, bit5 fill_active, [15:8] FIFO level.
    - Writing 1 to bit3 or bit4 clears that flag.
    - If a clear coincides with a new set event, the set wins.
  - 4 CTRL (RW): bit0 EN, bit1 IRQ_EN, [8+DIV_WIDTH-1:8] DIV.
  - 5–7: reads return 0, writes are ignored.
- Serialiser FSM, states IDLE, LOAD, LOW, HIGH:
  - IDLE: nCS=1, SCLK=0.
    - If EN and a fill is active: load the next fill byte (colour[15:8] then colour[7:0], DnC=1).
    - Else if EN and the FIFO is non-empty: pop one entry.
    - On a load, go to LOAD.
  - LOAD: 1 cycle. nCS=0, SCLK=0, DnC and SDIN (byte MSB) are valid.
  - LOW: DIV+1 cycles with SCLK=0, then go to HIGH.
  - HIGH: DIV+1 cycles with SCLK=1; the slave samples on the rising edge.
    - After bit 7 of the byte, apply the IDLE selection rule (fill byte, then FIFO); if a source is available and EN=1, go straight to LOAD with nCS kept 0.
    - If no source is available or EN=0, go to IDLE.
    - Otherwise go back to LOW and shift to the next bit; SDIN changes only on the HIGH→LOW transition.
  - Bytes go out MSB first. A byte occupies 1+16·(DIV+1) cycles.
- DnC and DIV are latched at LOAD. A CTRL write mid-byte takes effect at the next byte.
- Fill engine: the pixel counter decrements after each colour[7:0] byte. fill_active clears when the counter reaches 0 after the last low byte.
- TXDATA pushes during a fill are queued and sent after the fill completes.
- EN cleared mid-byte: the current byte completes, then the FSM goes to IDLE. FIFO contents and fill progress are retained.
- A simultaneous push and pop at full or empty is legal: level is unchanged and no OVF. A pointer wrap past FIFO_DEPTH-1 returns to 0.
- IRQ = IRQ_EN & EN & empty & !fill_active & state==IDLE.
- Reset mid-byte aborts the transfer immediately: nCS goes to 1, SCLK to 0, and the FIFO is flushed.

Test Plan:
- DIV=0, EN=1, push 0x15 with DnC=0 → nCS low for 17 cycles, SDIN pattern 0,0,0,1,0,1,0,1 on rising SCLK edges, DnC=0 throughout, IRQ rises after.
- DIV=3, push 0xA5 then 0x3C with DnC=1 → SCLK half-period 4 cycles, nCS stays low across both bytes, total 2·(1+64)=130 cycles.
- EN=0, push FIFO_DEPTH+1 entries → STATUS full=1, OVF=1, level=16. Write STATUS bit3=1 → OVF=0. EN=1 → exactly 16 bytes are sent, in push order.
- COLOUR=0x063C, FILLCNT=3 → byte stream 06,3C,06,3C,06,3C with DnC=1, then fill_active=0. A FILLCNT write while busy → ERR=1 and no extra bytes.
- During the fill, push 0x5C with DnC=0 → sent after the 6th fill byte.
- Assert HRESETn low during the 3rd bit of a byte → nCS=1 and SCLK=0 immediately; after release STATUS reads empty=1 and CTRL reads DIV=DEFAULT_DIV.

Source files
------------

// File: rtl/oled_spi_stream_if.sv
// AHB-Lite slave port bundle for the OLED serial streamer.
interface oled_spi_stream_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/oled_spi_stream.sv
// AHB-Lite OLED serial streamer: TX FIFO, programmable SCLK divider and a
// pixel-fill engine feeding a byte serialiser on nCS/DnC/SDIN/SCLK.
module oled_spi_stream #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 0,
  parameter int FILL_WIDTH  = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  oled_spi_stream_if.slave ahb,
  output logic             nCS,
  output logic             DnC,
  output logic             SDIN,
  output logic             SCLK,
  output logic             IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, LOW, HIGH} state_t;
  state_t state, state_nxt;

  // AHB address phase, consumed in the following (data) cycle
  logic       a_wr, a_rd;
  logic [2:0] a_off;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_wr  <= 1'b0;
      a_rd  <= 1'b0;
      a_off <= '0;
    end else begin
      a_wr  <= ahb.HSEL && ahb.HREADY && (ahb.HTRANS != 2'b00) && ahb.HWRITE;
      a_rd  <= ahb.HSEL && ahb.HREADY && (ahb.HTRANS != 2'b00) && !ahb.HWRITE;
      a_off <= ahb.HADDR[4:2];
    end
  end

  logic wr_txd, wr_col, wr_fill, wr_stat, wr_ctrl;
  assign wr_txd  = a_wr && (a_off == 3'd0);
  assign wr_col  = a_wr && (a_off == 3'd1);
  assign wr_fill = a_wr && (a_off == 3'd2);
  assign wr_stat = a_wr && (a_off == 3'd3);
  assign wr_ctrl = a_wr && (a_off == 3'd4);

  logic                 en, irq_en, ovf, err;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [15:0]          colour;

  // TX FIFO
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          empty, full, pop, push_ok, ovf_set;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign push_ok = wr_txd && (!full || pop);
  assign ovf_set = wr_txd && full && !pop;

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wptr] <= ahb.HWDATA[8:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Serialiser state and fill engine
  logic [7:0]            shreg, ld_byte;
  logic                  dnc_q, ld_dnc, cur_lo;
  logic [DIV_WIDTH-1:0]  div_q, div_cnt;
  logic [2:0]            bit_cnt;
  logic                  fill_active, fill_hi, fill_ok, fill_start;
  logic [FILL_WIDTH-1:0] fill_cnt;
  logic                  div_done, byte_done, fill_src, fifo_src, take;

  assign fill_ok    = empty && !fill_active && (state == IDLE);
  assign fill_start = wr_fill && fill_ok;

  always_comb begin
    state_nxt = state;
    div_done  = (div_cnt == div_q);
    byte_done = (state == HIGH) && div_done && (bit_cnt == 3'd7);
    // the low byte now finishing may be the last pixel, so it no longer counts
    fill_src  = en && fill_active &&
                !(byte_done && cur_lo && (fill_cnt == FILL_WIDTH'(1)));
    fifo_src  = en && !empty;
    take      = ((state == IDLE) || byte_done) && (fill_src || fifo_src);
    pop       = take && !fill_src;
    ld_byte   = fill_src ? (fill_hi ? colour[15:8] : colour[7:0]) : mem[rptr][7:0];
    ld_dnc    = fill_src || mem[rptr][8];
    case (state)
      IDLE:    if (take) state_nxt = LOAD;
      LOAD:    state_nxt = LOW;
      LOW:     if (div_done) state_nxt = HIGH;
      HIGH:    if (div_done) begin
                 if (bit_cnt != 3'd7) state_nxt = LOW;
                 else if (take)       state_nxt = LOAD;
                 else                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shreg   <= '0;
      dnc_q   <= 1'b0;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      cur_lo  <= 1'b0;
    end else begin
      if ((state == LOW || state == HIGH) && !div_done) div_cnt <= div_cnt + DIV_WIDTH'(1);
      else                                              div_cnt <= '0;
      if (take) begin
        shreg   <= ld_byte;
        dnc_q   <= ld_dnc;
        div_q   <= div_reg;
        cur_lo  <= fill_src && !fill_hi;
        bit_cnt <= '0;
      end else if (state == HIGH && div_done) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fill_active <= 1'b0;
      fill_hi     <= 1'b0;
      fill_cnt    <= '0;
    end else if (fill_start) begin
      fill_active <= |ahb.HWDATA[FILL_WIDTH-1:0];
      fill_cnt    <= ahb.HWDATA[FILL_WIDTH-1:0];
      fill_hi     <= 1'b1;
    end else begin
      if (take && fill_src) fill_hi <= !fill_hi;
      if (byte_done && cur_lo && fill_active) begin
        fill_cnt <= fill_cnt - FILL_WIDTH'(1);
        if (fill_cnt == FILL_WIDTH'(1)) fill_active <= 1'b0;
      end
    end
  end

  // Control and status registers; a set event beats a write-1-to-clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      div_reg <= DIV_WIDTH'(DEFAULT_DIV);
      colour  <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= ahb.HWDATA[0];
        irq_en  <= ahb.HWDATA[1];
        div_reg <= ahb.HWDATA[8 +: DIV_WIDTH];
      end
      if (wr_col) colour <= ahb.HWDATA[15:0];
      if (ovf_set)                         ovf <= 1'b1;
      else if (wr_stat && ahb.HWDATA[3])   ovf <= 1'b0;
      if (wr_fill && !fill_ok)             err <= 1'b1;
      else if (wr_stat && ahb.HWDATA[4])   err <= 1'b0;
    end
  end

  logic [7:0] lvl8;
  assign lvl8 = 8'(level);

  always_comb begin
    ahb.HRDATA = '0;
    if (a_rd) begin
      case (a_off)
        3'd1: ahb.HRDATA[15:0] = colour;
        3'd3: begin
          ahb.HRDATA[5:0]  = {fill_active, err, ovf, full, empty,
                              (state != IDLE) || fill_active};
          ahb.HRDATA[15:8] = lvl8;
        end
        3'd4: begin
          ahb.HRDATA[1:0]            = {irq_en, en};
          ahb.HRDATA[8 +: DIV_WIDTH] = div_reg;
        end
        default: ;
      endcase
    end
  end

  assign ahb.HREADYOUT = 1'b1;
  assign nCS  = (state == IDLE);
  assign SCLK = (state == HIGH);
  assign SDIN = shreg[7];
  assign DnC  = dnc_q;
  assign IRQ  = irq_en && en && empty && !fill_active && (state == IDLE);

  logic unused_ahb;
  assign unused_ahb = ^{ahb.HSIZE, ahb.HADDR, ahb.HWDATA};
endmodule
